gate_sweep_ctrl: RTL and testbench

GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

---
 rtl/gate_sweep_ctrl.sv | 118 +++++++++++
 tb/tb_gate_sweep_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_ctrl.sv
// Sequences all eight input vectors into a 3-input NAND under test and checks the fed-back output.
// Build option: SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module gate_sweep_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  input  logic       out_fb,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] fail_vec
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    WAIT   = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_e;

  state_e     state_q;
  logic [2:0] vec_q;
  logic [2:0] drv_q;
  logic [3:0] cnt_q;
  logic [3:0] err_q;
  logic [2:0] fv_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;

  logic       expect_bit;
  logic       mismatch;
  logic       finish;
  logic [3:0] err_d;

  assign expect_bit = ~&vec_q;
  // Exact compare so an undriven or unknown feedback never counts as a match.
  assign mismatch   = (out_fb !== expect_bit);
  assign err_d      = err_q + {3'b000, mismatch};

`ifdef SWEEP_STOP_ON_FAIL_EN
  assign finish = (vec_q == 3'b111) || mismatch;
`else
  assign finish = (vec_q == 3'b111);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      drv_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fv_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= APPLY;
            vec_q   <= '0;
            err_q   <= '0;
            fv_q    <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        APPLY: begin
          drv_q   <= vec_q;
          cnt_q   <= 4'(SETTLE - 1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= SAMPLE;
          else             cnt_q   <= cnt_q - 4'd1;
        end
        SAMPLE: begin
          if (mismatch) begin
            err_q <= err_d;
            if (err_q == '0) fv_q <= vec_q;
          end
          // done and pass are raised on DONE entry so they are visible for the whole DONE cycle.
          if (finish) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            vec_q   <= vec_q + 3'd1;
            state_q <= APPLY;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {in1, in2, in3} = drv_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign fail_vec        = fv_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: three instances (SETTLE = 2, 1, 15), expected values hand-computed.
module tb_gate_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] start_r = '0;
  int unsigned fb_mode = 0;  // instance 0 feedback: 0 ideal NAND, 1 tied high, 2 Z on vector 110

  logic [2:0]       fb_w;
  logic [2:0][2:0]  in_w;
  logic [2:0]       busy_w, done_w, pass_w;
  logic [2:0][3:0]  err_w;
  logic [2:0][2:0]  fv_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign fb_w[0] = (fb_mode == 1) ? 1'b1 :
                   ((fb_mode == 2) && (in_w[0] == 3'b110)) ? 1'bz : ~&in_w[0];
  assign fb_w[1] = ~&in_w[1];
  assign fb_w[2] = ~&in_w[2];

  gate_sweep_ctrl #(.SETTLE(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_r[0]),
    .in1(in_w[0][2]), .in2(in_w[0][1]), .in3(in_w[0][0]), .out_fb(fb_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .err_count(err_w[0]), .fail_vec(fv_w[0])
  );
  gate_sweep_ctrl #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_r[1]),
    .in1(in_w[1][2]), .in2(in_w[1][1]), .in3(in_w[1][0]), .out_fb(fb_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .err_count(err_w[1]), .fail_vec(fv_w[1])
  );
  gate_sweep_ctrl #(.SETTLE(15)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_r[2]),
    .in1(in_w[2][2]), .in2(in_w[2][1]), .in3(in_w[2][0]), .out_fb(fb_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .err_count(err_w[2]), .fail_vec(fv_w[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One start pulse; the accepting edge is clock 1 and done is expected on clock exp_clk.
  task automatic run_sweep(input int idx, input int exp_clk, input logic exp_pass,
                           input logic [3:0] exp_err, input logic [2:0] exp_fv);
    int n;
    @(negedge clk);
    start_r[idx] = 1'b1;
    @(posedge clk);
    n = 1;
    #1;
    start_r[idx] = 1'b0;
    check("busy_after_accept", 32'(busy_w[idx]), 32'd1);
    check("pass_cleared", 32'(pass_w[idx]), 32'd0);
    check("err_cleared", 32'(err_w[idx]), 32'd0);
    while (done_w[idx] !== 1'b1 && n < 400) begin
      @(posedge clk);
      n++;
      #1;
    end
    check("done_clock", 32'(n), 32'(exp_clk));
    check("busy_in_done", 32'(busy_w[idx]), 32'd1);
    check("pass", 32'(pass_w[idx]), 32'(exp_pass));
    check("err_count", 32'(err_w[idx]), 32'(exp_err));
    check("fail_vec", 32'(fv_w[idx]), 32'(exp_fv));
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done_w[idx]), 32'd0);
    check("busy_idle", 32'(busy_w[idx]), 32'd0);
    check("pass_held", 32'(pass_w[idx]), 32'(exp_pass));
    check("inputs_hold_111", 32'(in_w[idx]), 32'd7);
  endtask

  initial begin
    int first_done, second_done, pulses_early, pulses_all;
    logic b34, b35, saw_done;

    #1;
    check("rst_in", 32'(in_w[0]), 32'd0);
    check("rst_busy", 32'(busy_w[0]), 32'd0);
    check("rst_done", 32'(done_w[0]), 32'd0);
    check("rst_pass", 32'(pass_w[0]), 32'd0);
    check("rst_err", 32'(err_w[0]), 32'd0);
    check("rst_fv", 32'(fv_w[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    fb_mode = 0;
    run_sweep(0, 33, 1'b1, 4'd0, 3'b000);
    fb_mode = 2;
    run_sweep(0, 33, 1'b0, 4'd1, 3'b110);
    fb_mode = 1;
    run_sweep(0, 33, 1'b0, 4'd1, 3'b111);
    fb_mode = 0;

    // start held for 40 clocks: second sweep accepted on clock 35, done on 67.
    first_done = 0; second_done = 0; pulses_early = 0; pulses_all = 0;
    b34 = 1'b1; b35 = 1'b0;
    @(negedge clk);
    start_r[0] = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk);
      #1;
      if (done_w[0] === 1'b1) begin
        pulses_all++;
        if (n <= 40) pulses_early++;
        if (first_done == 0) first_done = n;
        else if (second_done == 0) second_done = n;
      end
      if (n == 34) b34 = busy_w[0];
      if (n == 35) b35 = busy_w[0];
      if (n == 40) start_r[0] = 1'b0;
    end
    check("hold_first_done", 32'(first_done), 32'd33);
    check("hold_pulses_in_40", 32'(pulses_early), 32'd1);
    check("hold_idle_gap", 32'(b34), 32'd0);
    check("hold_reaccept", 32'(b35), 32'd1);
    check("hold_second_done", 32'(second_done), 32'd67);
    check("hold_total_pulses", 32'(pulses_all), 32'd2);
    check("hold_pass", 32'(pass_w[0]), 32'd1);

    // Reset during WAIT of vector 011 (driven after clock 14).
    @(negedge clk);
    start_r[0] = 1'b1;
    @(posedge clk);
    #1;
    start_r[0] = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    check("mid_in_011", 32'(in_w[0]), 32'd3);
    check("mid_busy", 32'(busy_w[0]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_in", 32'(in_w[0]), 32'd0);
    check("async_busy", 32'(busy_w[0]), 32'd0);
    check("async_err", 32'(err_w[0]), 32'd0);
    check("async_pass", 32'(pass_w[0]), 32'd0);
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done_w[0] === 1'b1) saw_done = 1'b1;
      if (k == 3) rst = 1'b0;
    end
    check("no_done_after_abort", 32'(saw_done), 32'd0);
    run_sweep(0, 33, 1'b1, 4'd0, 3'b000);

    run_sweep(1, 25, 1'b1, 4'd0, 3'b000);
    run_sweep(2, 137, 1'b1, 4'd0, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
